pipe_stage_skid: RTL

- Generic, parametrised pipeline stage register for the processor pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed free-running stage registers with a valid/ready handshake, a 2-entry skid buffer (registered in_ready, no combinational ready path) and a synchronous flush that inserts a bubble.
- Carries a data bundle and a separate control bundle. Control is forced to a programmable "no-op" value on flush.

---
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic processor pipeline stage register with a valid/ready
// handshake and a 2-entry skid buffer. in_ready is registered, so there is no
// combinational path from out_ready back to in_ready. A synchronous flush
// empties the stage and drives a programmable no-op onto the control bundle.
module pipe_stage_skid #(
  parameter int                 DATA_W   = 96,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic accept;
  logic consume;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  // Next-state and storage update; reset beats flush, flush beats the handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (reset) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
    end else if (flush) begin
      // Any entry accepted this cycle is dropped; a consume this cycle has
      // already been sampled downstream, so nothing further is needed.
      state_d     = EMPTY;
      main_ctrl_d = CTRL_NOP;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the head can move.
          if (consume) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // Register state, ready and both storage entries on the same edge.
  always_ff @(posedge clock) begin
    state_q     <= state_d;
    in_ready_q  <= reset ? 1'b1 : in_ready_d;
    main_data_q <= main_data_d;
    main_ctrl_q <= main_ctrl_d;
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end

endmodule
